// File: rtl/rx78_cart_loader.sv
// HPS upload -> rx78 cartridge/ext-RAM write loader with byte FIFO and CPU hold.
// Optional checksum accumulator is built when RX78_LOADER_CHECKSUM_EN is defined.
module rx78_cart_loader #(
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int CART_INDEX  = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        upload,
    input  logic [7:0]  upload_index,
    input  logic        upload_wr,
    input  logic [24:0] upload_addr,
    input  logic [7:0]  upload_data,
    output logic        upload_wait,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic        mem_ext,
    output logic        cpu_reset,
    output logic        loaded,
    output logic        overflow,
    output logic [15:0] byte_count,
    output logic [15:0] checksum
);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [7:0]    hold_q, hold_d;
    logic          active, active_q, start;
    logic          clear, finish;
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q, count_d;
    logic [24:0]   fifo_mem [FIFO_DEPTH];
    logic [24:0]   head;
    logic          empty, full, push, pop, strobe, drop, in_map, map_ext;
    logic [15:0]   map_addr;
    logic          wait_q, overflow_q, loaded_q;
    logic [15:0]   byte_count_q, byte_count_d;

    assign active = upload && (upload_index == 8'(CART_INDEX));
    assign start  = active && !active_q;
    assign strobe = active && upload_wr;

    // Offsets 0x0000-0x3FFF land in cartridge ROM at 0x2000, 0x4000-0x8FFF in ext-RAM at 0x6000.
    assign in_map   = upload_addr < 25'h0_9000;
    assign map_ext  = upload_addr >= 25'h0_4000;
    assign map_addr = map_ext ? (16'h6000 + (upload_addr[15:0] - 16'h4000))
                              : (16'h2000 + upload_addr[15:0]);

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(FIFO_DEPTH));
    assign pop   = !empty && mem_ack;
    assign push  = strobe && in_map && (!full || pop);
    assign drop  = strobe && (!in_map || (full && !pop));

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + (AW+1)'(1);
        else if (pop && !push)
            count_d = count_q - (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wptr_q] <= {map_addr, upload_data, map_ext};
    end

    assign head     = fifo_mem[rptr_q];
    assign mem_req  = !empty;
    assign mem_addr = empty ? 16'h0000 : head[24:9];
    assign mem_data = empty ? 8'h00 : head[8:1];
    assign mem_ext  = empty ? 1'b0 : head[0];

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        clear   = 1'b0;
        finish  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    clear   = 1'b1;
                end
            end
            ST_LOAD: begin
                if (!active)
                    state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (start) begin
                    state_d = ST_LOAD;
                    clear   = 1'b1;
                end else if (empty) begin
                    state_d = ST_HOLD;
                    hold_d  = 8'(HOLD_CYCLES);
                end
            end
            ST_HOLD: begin
                // Leaving on the count of 1 makes the hold exactly HOLD_CYCLES clocks long.
                if (start) begin
                    state_d = ST_LOAD;
                    clear   = 1'b1;
                end else if (hold_q <= 8'd1) begin
                    state_d = ST_IDLE;
                    finish  = 1'b1;
                end else begin
                    hold_d = hold_q - 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        byte_count_d = clear ? 16'h0000 : byte_count_q;
        if (pop && byte_count_d != 16'hFFFF)
            byte_count_d = byte_count_d + 16'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            hold_q       <= 8'd0;
            active_q     <= 1'b0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            wait_q       <= 1'b0;
            overflow_q   <= 1'b0;
            loaded_q     <= 1'b0;
            byte_count_q <= 16'h0000;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            active_q     <= active;
            count_q      <= count_d;
            byte_count_q <= byte_count_d;
            if (push)
                wptr_q <= wptr_q + AW'(1);
            if (pop)
                rptr_q <= rptr_q + AW'(1);
            wait_q <= (count_q >= (AW+1)'(FIFO_DEPTH - 1));
            if (clear)
                overflow_q <= drop;
            else if (drop)
                overflow_q <= 1'b1;
            if (clear)
                loaded_q <= 1'b0;
            else if (finish)
                loaded_q <= !overflow_q;
        end
    end

`ifdef RX78_LOADER_CHECKSUM_EN
    logic [15:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = clear ? 16'h0000 : checksum_q;
        if (pop)
            checksum_d = checksum_d + {8'h00, head[8:1]};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            checksum_q <= 16'h0000;
        else
            checksum_q <= checksum_d;
    end

    assign checksum = checksum_q;
`else
    assign checksum = 16'h0000;
`endif

    assign upload_wait = wait_q;
    assign cpu_reset   = (state_q != ST_IDLE);
    assign loaded      = loaded_q;
    assign overflow    = overflow_q;
    assign byte_count  = byte_count_q;
endmodule

// File: tb/tb_rx78_cart_loader.sv
// Scoreboard bench for rx78_cart_loader: stimulus queues expected writes, a monitor pops them.
module tb_rx78_cart_loader;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        upload;
    logic [7:0]  upload_index;
    logic        upload_wr;
    logic [24:0] upload_addr;
    logic [7:0]  upload_data;
    logic        upload_wait;
    logic        mem_req;
    logic        mem_ack;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_ext;
    logic        cpu_reset;
    logic        loaded;
    logic        overflow;
    logic [15:0] byte_count;
    logic [15:0] checksum;

    int checks = 0;
    int errors = 0;
    logic [24:0] exp_q [$];

    rx78_cart_loader #(.FIFO_DEPTH(4), .HOLD_CYCLES(16), .CART_INDEX(1)) dut (
        .clk(clk), .reset_n(reset_n), .upload(upload), .upload_index(upload_index),
        .upload_wr(upload_wr), .upload_addr(upload_addr), .upload_data(upload_data),
        .upload_wait(upload_wait), .mem_req(mem_req), .mem_ack(mem_ack),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_ext(mem_ext),
        .cpu_reset(cpu_reset), .loaded(loaded), .overflow(overflow),
        .byte_count(byte_count), .checksum(checksum)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [24:0] a, input logic [7:0] d, input bit exp_push,
                          input logic [15:0] ea, input logic ee);
        upload_addr = a;
        upload_data = d;
        upload_wr   = 1'b1;
        if (exp_push)
            exp_q.push_back({ea, d, ee});
        tick();
        upload_wr = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (cpu_reset && n < 300) begin
            tick();
            n++;
        end
        check("idle_timeout", 32'(cpu_reset), 32'd0);
    endtask

    // Monitor: a write is consumed on the edge following a negedge with req and ack high.
    always @(negedge clk) begin
        if (reset_n && mem_req && mem_ack) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h ext %0d, none expected",
                         mem_addr, mem_data, mem_ext);
            end else begin
                logic [24:0] e;
                e = exp_q.pop_front();
                check("write", {7'd0, mem_addr, mem_data, mem_ext}, {7'd0, e});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] cs_t1, cs_t2, cs_t4;
        int sent;
`ifdef RX78_LOADER_CHECKSUM_EN
        cs_t1 = 16'h00AA;
        cs_t2 = 16'h00FF;
        cs_t4 = 16'h0306;
`else
        cs_t1 = 16'h0000;
        cs_t2 = 16'h0000;
        cs_t4 = 16'h0000;
`endif
        reset_n = 1'b0; upload = 1'b0; upload_index = 8'd0; upload_wr = 1'b0;
        upload_addr = '0; upload_data = '0; mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wait", 32'(upload_wait), 0);
        check("rst_req", 32'(mem_req), 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_cpu_reset", 32'(cpu_reset), 0);
        check("rst_loaded", 32'(loaded), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_count", 32'(byte_count), 0);
        check("rst_checksum", 32'(checksum), 0);
        reset_n = 1'b1;
        tick();

        // Test 1: four cartridge bytes with ack held high.
        upload = 1'b1; upload_index = 8'd1; mem_ack = 1'b1;
        tick();
        check("t1_cpu_reset_rise", 32'(cpu_reset), 1);
        strobe(25'h0, 8'h11, 1'b1, 16'h2000, 1'b0);
        strobe(25'h1, 8'h22, 1'b1, 16'h2001, 1'b0);
        strobe(25'h2, 8'h33, 1'b1, 16'h2002, 1'b0);
        strobe(25'h3, 8'h44, 1'b1, 16'h2003, 1'b0);
        upload = 1'b0;
        repeat (17) tick();
        check("t1_hold_still_high", 32'(cpu_reset), 1);
        tick();
        check("t1_hold_fall", 32'(cpu_reset), 0);
        check("t1_loaded", 32'(loaded), 1);
        check("t1_count", 32'(byte_count), 4);
        check("t1_checksum", 32'(checksum), 32'(cs_t1));

        // Test 2: ext-RAM window edges.
        upload = 1'b1; mem_ack = 1'b0;
        tick();
        check("t2_count_cleared", 32'(byte_count), 0);
        strobe(25'h4000, 8'h5A, 1'b1, 16'h6000, 1'b1);
        check("t2_req_latency", 32'(mem_req), 1);
        strobe(25'h8FFF, 8'hA5, 1'b1, 16'hAFFF, 1'b1);
        mem_ack = 1'b1;
        upload = 1'b0;
        wait_idle();
        check("t2_overflow", 32'(overflow), 0);
        check("t2_loaded", 32'(loaded), 1);
        check("t2_count", 32'(byte_count), 2);
        check("t2_checksum", 32'(checksum), 32'(cs_t2));

        // Test 4: back-pressure with ack held low, then a 4-byte burst.
        upload = 1'b1; mem_ack = 1'b0;
        tick();
        sent = 0;
        for (int i = 0; i < 8; i++) begin
            if (!upload_wait) begin
                strobe(25'h10 + 25'(sent), 8'hC0 + 8'(sent), 1'b1, 16'h2010 + 16'(sent), 1'b0);
                sent++;
            end else begin
                tick();
            end
        end
        check("t4_strobes_sent", 32'(sent), 4);
        check("t4_wait_high", 32'(upload_wait), 1);
        check("t4_overflow", 32'(overflow), 0);
        mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t4_burst_req", 32'(mem_req), 1);
            tick();
        end
        check("t4_burst_done", 32'(mem_req), 0);
        upload = 1'b0;
        wait_idle();
        check("t4_count", 32'(byte_count), 4);
        check("t4_checksum", 32'(checksum), 32'(cs_t4));
        check("t4_loaded", 32'(loaded), 1);

        // Test 3: offset beyond the map.
        upload = 1'b1;
        tick();
        strobe(25'h9000, 8'h99, 1'b0, 16'h0000, 1'b0);
        check("t3_no_req", 32'(mem_req), 0);
        check("t3_overflow", 32'(overflow), 1);
        upload = 1'b0;
        wait_idle();
        check("t3_loaded", 32'(loaded), 0);
        check("t3_count", 32'(byte_count), 0);

        // Test 5: foreign index is ignored.
        upload = 1'b1; upload_index = 8'd2;
        tick();
        strobe(25'h0, 8'h77, 1'b0, 16'h0000, 1'b0);
        check("t5_cpu_reset", 32'(cpu_reset), 0);
        check("t5_no_req", 32'(mem_req), 0);
        upload = 1'b0;
        repeat (3) tick();
        check("t5_overflow_kept", 32'(overflow), 1);
        check("t5_loaded_kept", 32'(loaded), 0);

        // Test 6: reset asserted during HOLD.
        upload = 1'b1; upload_index = 8'd1;
        tick();
        strobe(25'h5, 8'h66, 1'b1, 16'h2005, 1'b0);
        upload = 1'b0;
        repeat (5) tick();
        check("t6_in_hold", 32'(cpu_reset), 1);
        check("t6_count", 32'(byte_count), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rst_cpu_reset", 32'(cpu_reset), 0);
        check("t6_rst_count", 32'(byte_count), 0);
        check("t6_rst_overflow", 32'(overflow), 0);
        check("t6_rst_req", 32'(mem_req), 0);
        check("t6_rst_wait", 32'(upload_wait), 0);
        tick();
        reset_n = 1'b1;
        repeat (20) tick();
        check("t6_idle_after", 32'(cpu_reset), 0);
        check("t6_loaded_after", 32'(loaded), 0);

        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
